// File: rtl/dq_blok_siralayici.sv
// Expands run-length symbols into 64 zigzag-ordered coefficients per 8x8 block toward the dequantizer.
// Optional block counter output enabled by defining DQ_BLOK_SAYAC_EN.
module dq_blok_siralayici #(
    parameter int PIXEL_BIT = 12,
    parameter int BLOCK_BIT = 3,
    parameter int RUN_BIT   = 4
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [RUN_BIT-1:0]   rl_run_i,
    input  logic [PIXEL_BIT-1:0] rl_deger_i,
    input  logic                 rl_eob_i,
    input  logic                 rl_gecerli_i,
    output logic                 rl_hazir_o,
    output logic [PIXEL_BIT-1:0] dq_veri_o,
    output logic [BLOCK_BIT-1:0] dq_row_o,
    output logic [BLOCK_BIT-1:0] dq_col_o,
    output logic                 dq_gecerli_o,
    input  logic                 dq_hazir_i,
    output logic                 blok_son_o,
    output logic                 hata_o
`ifdef DQ_BLOK_SAYAC_EN
    ,
    output logic [15:0]          blok_sayac_o
`endif
);

    localparam int IDX_BIT = 2 * BLOCK_BIT;

    typedef enum logic [1:0] {BOSTA, SIFIR, DEGER, DOLDUR} state_t;

    // Zigzag index -> natural position {row, col}
    localparam logic [IDX_BIT-1:0] ZZ [64] = '{
        6'd0,  6'd1,  6'd8,  6'd16, 6'd9,  6'd2,  6'd3,  6'd10,
        6'd17, 6'd24, 6'd32, 6'd25, 6'd18, 6'd11, 6'd4,  6'd5,
        6'd12, 6'd19, 6'd26, 6'd33, 6'd40, 6'd48, 6'd41, 6'd34,
        6'd27, 6'd20, 6'd13, 6'd6,  6'd7,  6'd14, 6'd21, 6'd28,
        6'd35, 6'd42, 6'd49, 6'd56, 6'd57, 6'd50, 6'd43, 6'd36,
        6'd29, 6'd22, 6'd15, 6'd23, 6'd30, 6'd37, 6'd44, 6'd51,
        6'd58, 6'd59, 6'd52, 6'd45, 6'd38, 6'd31, 6'd39, 6'd46,
        6'd53, 6'd60, 6'd61, 6'd54, 6'd47, 6'd55, 6'd62, 6'd63
    };

    state_t               state, mode, nxt;
    logic [RUN_BIT-1:0]   run_q, run_c, run_n;
    logic [PIXEL_BIT-1:0] val_q, val_c, coef;
    logic [IDX_BIT-1:0]   idx;
    logic                 take, adv, emit, last, ovf;

    assign take = rl_gecerli_i & rl_hazir_o;
    assign adv  = ~dq_gecerli_o | dq_hazir_i;
    assign last = &idx;

    // A freshly accepted symbol is acted on in its accept cycle so the first
    // coefficient appears one cycle later; otherwise the latched context runs.
    always_comb begin
        mode  = state;
        run_c = run_q;
        val_c = val_q;
        if (take) begin
            run_c = rl_run_i;
            val_c = rl_deger_i;
            if (rl_eob_i)
                mode = DOLDUR;
            else if (rl_run_i != '0)
                mode = SIFIR;
            else
                mode = DEGER;
        end
    end

    assign emit = adv && (mode != BOSTA);
    assign coef = (mode == DEGER) ? val_c : '0;

    always_comb begin
        nxt   = mode;
        run_n = run_c;
        ovf   = 1'b0;
        if (emit) begin
            case (mode)
                SIFIR: begin
                    // A zero landing on the final slot leaves no room for the value.
                    if (last) begin
                        nxt = BOSTA;
                        ovf = 1'b1;
                    end else begin
                        run_n = run_c - RUN_BIT'(1);
                        if (run_c == RUN_BIT'(1))
                            nxt = DEGER;
                    end
                end
                DEGER:   nxt = BOSTA;
                DOLDUR:  if (last) nxt = BOSTA;
                default: nxt = BOSTA;
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state        <= BOSTA;
            run_q        <= '0;
            val_q        <= '0;
            idx          <= '0;
            rl_hazir_o   <= 1'b0;
            dq_gecerli_o <= 1'b0;
            dq_veri_o    <= '0;
            dq_row_o     <= '0;
            dq_col_o     <= '0;
            blok_son_o   <= 1'b0;
            hata_o       <= 1'b0;
        end else begin
            state      <= nxt;
            run_q      <= run_n;
            val_q      <= val_c;
            rl_hazir_o <= (nxt == BOSTA);
            if (ovf)
                hata_o <= 1'b1;
            if (adv) begin
                dq_gecerli_o <= emit;
                if (emit) begin
                    dq_veri_o              <= coef;
                    {dq_row_o, dq_col_o}   <= ZZ[idx];
                    blok_son_o             <= last;
                    idx                    <= idx + IDX_BIT'(1);
                end else begin
                    blok_son_o <= 1'b0;
                end
            end
        end
    end

`ifdef DQ_BLOK_SAYAC_EN
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)
            blok_sayac_o <= '0;
        else if (dq_gecerli_o && dq_hazir_i && blok_son_o)
            blok_sayac_o <= blok_sayac_o + 16'd1;
    end
`endif

endmodule

// File: tb/tb_dq_blok_siralayici.sv
// Scoreboard bench for dq_blok_siralayici: expected coefficients are queued per symbol and
// popped on each output transfer; zigzag positions come from an independent diagonal walk.
module tb_dq_blok_siralayici;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [3:0]  rl_run = '0;
    logic [11:0] rl_deger = '0;
    logic        rl_eob = 1'b0;
    logic        rl_gecerli = 1'b0;
    logic        rl_hazir;
    logic [11:0] dq_veri;
    logic [2:0]  dq_row, dq_col;
    logic        dq_gecerli;
    logic        dq_hazir = 1'b1;
    logic        blok_son;
    logic        hata;
`ifdef DQ_BLOK_SAYAC_EN
    logic [15:0] blok_sayac;
`endif

    always #5 clk = ~clk;

    dq_blok_siralayici #(.PIXEL_BIT(12), .BLOCK_BIT(3), .RUN_BIT(4)) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .rl_run_i     (rl_run),
        .rl_deger_i   (rl_deger),
        .rl_eob_i     (rl_eob),
        .rl_gecerli_i (rl_gecerli),
        .rl_hazir_o   (rl_hazir),
        .dq_veri_o    (dq_veri),
        .dq_row_o     (dq_row),
        .dq_col_o     (dq_col),
        .dq_gecerli_o (dq_gecerli),
        .dq_hazir_i   (dq_hazir),
        .blok_son_o   (blok_son),
        .hata_o       (hata)
`ifdef DQ_BLOK_SAYAC_EN
        ,
        .blok_sayac_o (blok_sayac)
`endif
    );

    typedef struct packed {
        logic [11:0] data;
        logic [2:0]  row;
        logic [2:0]  col;
        logic        last;
    } exp_t;

    exp_t        q[$];
    int          n_checks = 0;
    int          n_errors = 0;
    int          xfers = 0;
    int          m_idx = 0;
    logic [2:0]  zr[64];
    logic [2:0]  zc[64];
    logic        sends_done = 1'b0;

    // Output monitor: pops the scoreboard on every transfer, checks hold while stalled.
    initial begin
        logic stall_prev;
        exp_t held, obs, e;
        stall_prev = 1'b0;
        held = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                stall_prev = 1'b0;
            end else begin
                obs = {dq_veri, dq_row, dq_col, blok_son};
                if (stall_prev) begin
                    n_checks++;
                    if (dq_gecerli !== 1'b1 || obs !== held) begin
                        n_errors++;
                        $display("FAIL hold_stable got v=%b %h expected v=1 %h", dq_gecerli, obs, held);
                    end
                end
                if (dq_gecerli && dq_hazir) begin
                    xfers++;
                    n_checks++;
                    if (q.size() == 0) begin
                        n_errors++;
                        $display("FAIL unexpected_coef got %h expected none", obs);
                    end else begin
                        e = q.pop_front();
                        if (obs !== e) begin
                            n_errors++;
                            $display("FAIL coef got data=%h rc=%0d,%0d last=%b expected data=%h rc=%0d,%0d last=%b",
                                     dq_veri, dq_row, dq_col, blok_son, e.data, e.row, e.col, e.last);
                        end
                    end
                end
                stall_prev = dq_gecerli && !dq_hazir;
                held = obs;
            end
        end
    end

    task automatic push(input logic [11:0] d);
        exp_t e;
        e.data = d;
        e.row  = zr[m_idx];
        e.col  = zc[m_idx];
        e.last = (m_idx == 63);
        q.push_back(e);
        m_idx = (m_idx + 1) % 64;
    endtask

    // Queues the expected expansion of one symbol, then offers it until accepted.
    task automatic send(input int run, input int val, input logic eob);
        int n;
        logic ovf;
        logic [11:0] v;
        v = val[11:0];
        ovf = 1'b0;
        if (eob) begin
            do push(12'd0); while (m_idx != 0);
        end else begin
            for (int k = 0; k < run; k++) begin
                if (m_idx == 63) begin
                    push(12'd0);
                    ovf = 1'b1;
                    break;
                end
                push(12'd0);
            end
            if (!ovf) push(v);
        end
        @(posedge clk);
        #1;
        rl_run = run[3:0];
        rl_deger = v;
        rl_eob = eob;
        rl_gecerli = 1'b1;
        n = 0;
        @(negedge clk);
        while (!rl_hazir && n < 400) begin
            n++;
            @(negedge clk);
        end
        n_checks++;
        if (rl_hazir !== 1'b1) begin
            n_errors++;
            $display("FAIL accept_timeout rl_hazir=%b expected 1", rl_hazir);
        end
        @(posedge clk);
        #1;
        rl_gecerli = 1'b0;
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (q.size() != 0 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        n_checks++;
        if (q.size() != 0) begin
            n_errors++;
            $display("FAIL drain_timeout pending=%0d expected 0", q.size());
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic check_hata(input logic exp_v, input string tag);
        n_checks++;
        if (hata !== exp_v) begin
            n_errors++;
            $display("FAIL %s hata=%b expected %b", tag, hata, exp_v);
        end
    endtask

    task automatic check_zero_outputs(input string tag);
        n_checks++;
        if ({dq_gecerli, dq_veri, dq_row, dq_col, blok_son, hata, rl_hazir} !== '0) begin
            n_errors++;
            $display("FAIL %s got v=%b d=%h r=%0d c=%0d last=%b hata=%b rdy=%b expected all 0",
                     tag, dq_gecerli, dq_veri, dq_row, dq_col, blok_son, hata, rl_hazir);
        end
`ifdef DQ_BLOK_SAYAC_EN
        n_checks++;
        if (blok_sayac !== 16'd0) begin
            n_errors++;
            $display("FAIL %s_sayac got %0d expected 0", tag, blok_sayac);
        end
`endif
    endtask

    task automatic test_reset();
        #1 rst = 1'b1;
        #1 check_zero_outputs("reset");
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        @(negedge clk);
        n_checks++;
        if (rl_hazir !== 1'b1) begin
            n_errors++;
            $display("FAIL ready_after_reset rl_hazir=%b expected 1", rl_hazir);
        end
    endtask

    task automatic test_eob_only();
        send(0, 0, 1'b1);
        wait_drain();
        check_hata(1'b0, "eob_only_hata");
    endtask

    task automatic test_mixed();
        send(0, 50, 1'b0);
        send(2, -3, 1'b0);
        send(0, 0, 1'b1);
        wait_drain();
    endtask

    task automatic test_zrl();
        repeat (3) send(15, 0, 1'b0);
        send(15, 7, 1'b0);
        send(0, 21, 1'b0);
        send(0, 0, 1'b1);
        wait_drain();
        check_hata(1'b0, "zrl_hata");
    endtask

    task automatic test_overflow();
        repeat (3) send(15, 0, 1'b0);
        send(11, 9, 1'b0);
        send(10, 5, 1'b0);
        wait_drain();
        check_hata(1'b1, "overflow_hata");
        send(0, 0, 1'b1);
        wait_drain();
        check_hata(1'b1, "overflow_sticky");
    endtask

    task automatic test_back_to_back_stall();
        int start;
        start = xfers;
        sends_done = 1'b0;
        dq_hazir = 1'b0;
        fork
            begin
                send(3, 12, 1'b0);
                send(0, 0, 1'b1);
                sends_done = 1'b1;
            end
            begin
                for (int i = 0; i < 600; i++) begin
                    @(posedge clk);
                    #1 dq_hazir = ~dq_hazir;
                    if (sends_done && q.size() == 0) break;
                end
            end
        join
        dq_hazir = 1'b1;
        wait_drain();
        n_checks++;
        if (xfers - start != 64) begin
            n_errors++;
            $display("FAIL stall_transfers got %0d expected 64", xfers - start);
        end
    endtask

    task automatic test_reset_mid_block();
        dq_hazir = 1'b0;
        send(12, 3, 1'b0);
        repeat (3) @(posedge clk);
        #3 rst = 1'b1;
        #1 check_zero_outputs("reset_mid");
        q.delete();
        m_idx = 0;
        @(posedge clk);
        #1 rst = 1'b0;
        dq_hazir = 1'b1;
        send(0, 0, 1'b1);
        wait_drain();
        check_hata(1'b0, "after_reset_hata");
`ifdef DQ_BLOK_SAYAC_EN
        n_checks++;
        if (blok_sayac !== 16'd1) begin
            n_errors++;
            $display("FAIL blok_sayac got %0d expected 1", blok_sayac);
        end
`endif
    endtask

    initial begin
        int r, c;
        r = 0;
        c = 0;
        for (int i = 0; i < 64; i++) begin
            zr[i] = r[2:0];
            zc[i] = c[2:0];
            if (((r + c) % 2) == 0) begin
                if (c == 7) r++;
                else if (r == 0) c++;
                else begin r--; c++; end
            end else begin
                if (r == 7) c++;
                else if (c == 0) r++;
                else begin r++; c--; end
            end
        end
        test_reset();
        test_eob_only();
        test_mixed();
        test_zrl();
        test_overflow();
        test_back_to_back_stall();
        test_reset_mid_block();
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog time limit reached with %0d pending", q.size());
        $fatal(1, "watchdog");
    end

endmodule
